// File: rtl/pipeline_if.sv
// ============================================================================
// pipeline_if
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of
// the IF/ID register. It holds the fetch PC and issues one word request at a
// time to instruction memory over a req/ack handshake. Returned words are
// buffered with their PCs in a 2-entry FIFO. The head of the FIFO is
// presented to decode. A branch/jump redirect flushes the buffer and steers
// fetch to the new target.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-high
//   stall          decode/hazard stall, head is not consumed this cycle
//   branch_ce      redirect request from branch resolution
//   branch_target  redirect address (low two bits are ignored)
//   mem_req        instruction-memory read request (registered)
//   mem_addr       word address of the request (registered)
//   mem_ack        memory accepted the request, mem_rdata valid this cycle
//   mem_rdata      instruction word returned by memory
//   inst_valid     head entry valid toward IF/ID
//   inst_out       head instruction (NOP when the buffer is empty)
//   pc_out         PC of the head instruction (holds last value when empty)
// ============================================================================
module pipeline_if #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_ce,
   input  logic [31:0] branch_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [1:0]  DEPTH = FIFO_DEPTH[1:0];

   // Memory-side state. WAIT means a live request is in flight. DISCARD means
   // a request is still in flight but a redirect has made its data stale.
   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_WAIT,
      MEM_DISCARD
   } memState_e;

   memState_e   memState_q;
   logic [31:0] memAddr_q;
   logic [31:0] fetchPc_q;
   logic [31:0] fetchPc_d;
   logic [1:0]  count_q;
   logic [1:0]  count_d;
   logic [31:0] slot0Pc_q;
   logic [31:0] slot0Inst_q;
   logic [31:0] slot1Pc_q;
   logic [31:0] slot1Inst_q;

   logic        outstanding;
   logic        pushEn;
   logic        popEn;
   logic        issueEn;
   logic [31:0] targetAligned;

   // Redirect targets are word addresses; misaligned low bits are dropped.
   assign targetAligned = branch_target & ~32'h0000_0003;

   // Control decisions for this cycle. A redirect overrides push, pop and
   // issue. A new request is only started when nothing is in flight and the
   // buffer still has a free slot for its data, which keeps
   // count + outstanding within the buffer depth.
   always_comb begin
      outstanding = (memState_q != MEM_IDLE);
      pushEn      = outstanding & mem_ack & (memState_q == MEM_WAIT) & ~branch_ce;
      popEn       = (count_q != 2'd0) & ~stall & ~branch_ce;
      issueEn     = ~outstanding & (count_q < DEPTH) & ~branch_ce;

      fetchPc_d = fetchPc_q;
      if (branch_ce) begin
         fetchPc_d = targetAligned;
      end else if (pushEn) begin
         fetchPc_d = memAddr_q + 32'd4;
      end

      count_d = count_q;
      if (branch_ce) begin
         count_d = 2'd0;
      end else if (pushEn && !popEn) begin
         count_d = count_q + 2'd1;
      end else if (!pushEn && popEn) begin
         count_d = count_q - 2'd1;
      end
   end

   // Request handshake FSM. The address is latched when the request starts,
   // so a redirect arriving mid-request cannot disturb mem_addr. A redirect
   // while waiting turns the pending response into one to be thrown away. An
   // ack in the same cycle as the redirect simply finishes the request; its
   // data is dropped by the push gating above.
   always_ff @(posedge clk) begin
      if (rst) begin
         memState_q <= MEM_IDLE;
         memAddr_q  <= RESET_PC;
      end else begin
         case (memState_q)
            MEM_IDLE: begin
               if (issueEn) begin
                  memState_q <= MEM_WAIT;
                  memAddr_q  <= fetchPc_q;
               end
            end
            MEM_WAIT: begin
               if (mem_ack) begin
                  memState_q <= MEM_IDLE;
               end else if (branch_ce) begin
                  memState_q <= MEM_DISCARD;
               end
            end
            MEM_DISCARD: begin
               if (mem_ack) begin
                  memState_q <= MEM_IDLE;
               end
            end
            default: begin
               memState_q <= MEM_IDLE;
            end
         endcase
      end
   end

   // Fetch PC: advances past each accepted word and jumps on redirect.
   // The 32-bit add wraps naturally from the top of the address space to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc_q <= RESET_PC;
      end else begin
         fetchPc_q <= fetchPc_d;
      end
   end

   // Two-entry fetch buffer, slot0 is always the head. Popping the last
   // entry leaves slot0 untouched so pc_out keeps its last value. A redirect
   // only clears the count, again leaving pc_out where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= 2'd0;
         slot0Pc_q   <= 32'h0000_0000;
         slot0Inst_q <= NOP;
         slot1Pc_q   <= 32'h0000_0000;
         slot1Inst_q <= NOP;
      end else begin
         count_q <= count_d;
         case ({pushEn, popEn})
            2'b10: begin
               if (count_q == 2'd0) begin
                  slot0Pc_q   <= memAddr_q;
                  slot0Inst_q <= mem_rdata;
               end else begin
                  slot1Pc_q   <= memAddr_q;
                  slot1Inst_q <= mem_rdata;
               end
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  slot0Pc_q   <= slot1Pc_q;
                  slot0Inst_q <= slot1Inst_q;
               end
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  slot0Pc_q   <= memAddr_q;
                  slot0Inst_q <= mem_rdata;
               end else begin
                  slot0Pc_q   <= slot1Pc_q;
                  slot0Inst_q <= slot1Inst_q;
                  slot1Pc_q   <= memAddr_q;
                  slot1Inst_q <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are straight decodes of registered state.
   assign mem_req    = outstanding;
   assign mem_addr   = memAddr_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst_out   = inst_valid ? slot0Inst_q : NOP;
   assign pc_out     = slot0Pc_q;

endmodule
